reg_scoreboard_ctrl: RTL and testbench
======================================

Name: reg_scoreboard_ctrl

Overview:
- Issue-hazard controller between the decode stage and the execute bus.
- Tracks outstanding register writes per architectural register and grants issue only when sources are clean, the destination has write-tracking headroom and execute is not busy.
- Replaces the decode stage's polling of register validity with one registered scoreboard, shared by decode (issue side) and writeback (retire side).

Parameters:
- NUM_REGS, 16, number of architectural registers tracked.
- REG_W, 4, register-ID width; must satisfy 2**REG_W >= NUM_REGS.
- CNT_W, 2, width of each per-register outstanding-write counter; max 2**CNT_W-1 in flight per register.
- STALL_W, 32, width of the stall-cycle counter.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- issue_valid, in, 1, decode presents an instruction.
- issue_src_a, in, REG_W, first source register ID.
- issue_src_a_used, in, 1, src_a participates in the hazard check.
- issue_src_b, in, REG_W, second source register ID.
- issue_src_b_used, in, 1, src_b participates in the hazard check.
- issue_dst, in, REG_W, destination register ID.
- issue_dst_used, in, 1, instruction writes issue_dst.
- exec_busy, in, 1, execute bus busy.
- issue_ready, out, 1, issue permitted this cycle (combinational).
- wb_valid, in, 1, writeback retires one register write.
- wb_reg, in, REG_W, register being retired.
- flush, in, 1, synchronous clear of all tracking (pipeline flush or halt).
- busy_mask, out, NUM_REGS, bit r = 1 iff cnt[r] != 0 (registered).
- inflight, out, REG_W+CNT_W, total outstanding writes.
- stall_cycles, out, STALL_W, saturating count of issue_valid && !issue_ready cycles.
- wb_underflow, out, 1, sticky error flag.

Behaviour:
- Reset (async, reset_n=0): all cnt=0, busy_mask=0, inflight=0, stall_cycles=0, wb_underflow=0.
- issue_ready = !exec_busy && !(src_a_used && cnt[src_a]!=0) && !(src_b_used && cnt[src_b]!=0) && !(dst_used && cnt[dst]==MAX). It does not depend on issue_valid.
- WAW is allowed. An instruction with dst pending may issue while below MAX; execute retires in order.
- No writeback bypass: a wb in cycle N affects issue_ready only from cycle N+1.
- fire = issue_valid && issue_ready. On fire with dst_used: cnt[dst]++ at the clock edge.
- On wb_valid with cnt[wb_reg]!=0: cnt[wb_reg]--.
- On wb_valid with cnt[wb_reg]==0: the counter holds and wb_underflow is set. wb_underflow clears only on reset.
- Same-cycle fire (dst_used) and wb to the same register: cnt unchanged. To different registers: both update.
- Source equal to dst: the source check applies independently. Example: ADD r3,r3,#1 with cnt[3]=1 stalls.
- IDs >= NUM_REGS: treated as cnt=0 and ignored on update; wb to such an ID does not raise underflow.
- inflight: +1 per fire with dst_used, -1 per valid non-underflow wb, net 0 when both occur. It always equals the sum of cnt.
- stall_cycles: increments when issue_valid && !issue_ready, saturates at all-ones, cleared only by reset (not by flush).
- flush: at the next edge all cnt=0, busy_mask=0, inflight=0. Flush overrides a same-cycle fire or wb: neither is recorded and no underflow is raised. issue_ready is unaffected in the flush cycle.
- Reset mid-operation clears everything asynchronously. Outstanding wb pulses after reset raise underflow; that is the required behaviour.
- Outputs busy_mask and inflight are registered, with a one-cycle view of the counter state.

Test Plan:
- Reset, then issue dst=r5 (valid, exec_busy=0) -> issue_ready=1. Next cycle busy_mask=0x0020, inflight=1. Then issue src_a=r5 -> issue_ready=0, stall_cycles increments each cycle. wb r5 in cycle N -> ready still 0 in N, 1 in N+1.
- Issue dst=r2 three times with no wb -> cnt[2]=3. Fourth dst=r2 -> issue_ready=0. One wb r2 -> ready next cycle, inflight 3->2->3.
- Same cycle fire dst=r7 (cnt[7]=1) and wb r7 -> cnt[7] stays 1, inflight unchanged, busy_mask bit7 stays 1.
- wb r9 with cnt[9]=0 -> wb_underflow=1 next cycle, inflight unchanged. It stays 1 through flush and clears only on reset_n low.
- cnt[1]=2, cnt[4]=1, plus flush and a same-cycle fire dst=r6 -> next cycle busy_mask=0, inflight=0, stall_cycles preserved.
- exec_busy=1 with clean registers and issue_valid for 10 cycles -> issue_ready=0 and stall_cycles=10. With stall_cycles preloaded to 0xFFFFFFFF by forcing, it stays saturated.

Source files
------------

// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl
//   Issue-hazard scoreboard between decode and the execute bus. Each
//   architectural register has a small counter of writes that have been issued
//   but not yet retired. Decode may issue when its sources have no pending
//   writes, its destination counter has headroom, and execute is not busy.
//   Writeback retires one pending write per cycle.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   issue_valid            decode presents an instruction
//   issue_src_a/_used      first source ID and its participation flag
//   issue_src_b/_used      second source ID and its participation flag
//   issue_dst/_used        destination ID and its write flag
//   exec_busy              execute bus cannot accept
//   issue_ready            combinational issue permission
//   wb_valid, wb_reg       writeback retires one write to wb_reg
//   flush                  synchronous clear of all write tracking
//   busy_mask              registered, bit r set while register r has pending writes
//   inflight               registered total of pending writes
//   stall_cycles           saturating count of issue_valid && !issue_ready cycles
//   wb_underflow           sticky: writeback seen for a register with nothing pending
module reg_scoreboard_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int REG_W    = 4,
    parameter int CNT_W    = 2,
    parameter int STALL_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   issue_valid,
    input  logic [REG_W-1:0]       issue_src_a,
    input  logic                   issue_src_a_used,
    input  logic [REG_W-1:0]       issue_src_b,
    input  logic                   issue_src_b_used,
    input  logic [REG_W-1:0]       issue_dst,
    input  logic                   issue_dst_used,
    input  logic                   exec_busy,
    output logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_reg,
    input  logic                   flush,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic [REG_W+CNT_W-1:0] inflight,
    output logic [STALL_W-1:0]     stall_cycles,
    output logic                   wb_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]       cnt     [NUM_REGS];
    logic [CNT_W-1:0]       cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0]    busy_nxt;
    logic [REG_W+CNT_W-1:0] inflight_nxt;

    logic src_a_hz, src_b_hz, dst_full;
    logic fire, inc_any, wb_hit, wb_ok, wb_under;

    // IDs beyond the tracked range read as clean and are never updated.
    function automatic logic id_ok(input logic [REG_W-1:0] id);
        return int'(id) < NUM_REGS;
    endfunction

    // Hazard check: reads only registered counters, so a writeback in this
    // cycle cannot release a stall until the next cycle.
    always_comb begin
        src_a_hz    = issue_src_a_used && id_ok(issue_src_a) && (cnt[issue_src_a] != '0);
        src_b_hz    = issue_src_b_used && id_ok(issue_src_b) && (cnt[issue_src_b] != '0);
        dst_full    = issue_dst_used   && id_ok(issue_dst)   && (cnt[issue_dst] == CNT_MAX);
        issue_ready = !exec_busy && !src_a_hz && !src_b_hz && !dst_full;
    end

    // Next-state counters. Increment and decrement on the same register cancel.
    // Flush discards both this cycle's issue and writeback.
    always_comb begin
        fire     = issue_valid && issue_ready;
        inc_any  = fire && issue_dst_used && id_ok(issue_dst);
        wb_hit   = wb_valid && id_ok(wb_reg);
        wb_ok    = wb_hit && (cnt[wb_reg] != '0);
        wb_under = wb_hit && (cnt[wb_reg] == '0) && !flush;
        busy_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = cnt[r];
            if (flush) begin
                cnt_nxt[r] = '0;
            end else if (inc_any && issue_dst == REG_W'(r) && !(wb_ok && wb_reg == REG_W'(r))) begin
                cnt_nxt[r] = cnt[r] + CNT_W'(1);
            end else if (wb_ok && wb_reg == REG_W'(r) && !(inc_any && issue_dst == REG_W'(r))) begin
                cnt_nxt[r] = cnt[r] - CNT_W'(1);
            end
            busy_nxt[r] = (cnt_nxt[r] != '0);
        end
        inflight_nxt = inflight;
        if (flush) begin
            inflight_nxt = '0;
        end else if (inc_any && !wb_ok) begin
            inflight_nxt = inflight + 1'b1;
        end else if (wb_ok && !inc_any) begin
            inflight_nxt = inflight - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            busy_mask    <= '0;
            inflight     <= '0;
            stall_cycles <= '0;
            wb_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            busy_mask <= busy_nxt;
            inflight  <= inflight_nxt;
            // Stall counter survives flush; it is a performance statistic.
            if (issue_valid && !issue_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (wb_under) begin
                wb_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
module tb_reg_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic [3:0]  issue_src_a;
    logic        issue_src_a_used;
    logic [3:0]  issue_src_b;
    logic        issue_src_b_used;
    logic [3:0]  issue_dst;
    logic        issue_dst_used;
    logic        exec_busy;
    logic        issue_ready;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic        flush;
    logic [15:0] busy_mask;
    logic [5:0]  inflight;
    logic [31:0] stall_cycles;
    logic        wb_underflow;

    int n_chk  = 0;
    int n_fail = 0;

    reg_scoreboard_ctrl #(
        .NUM_REGS(16), .REG_W(4), .CNT_W(2), .STALL_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid),
        .issue_src_a(issue_src_a), .issue_src_a_used(issue_src_a_used),
        .issue_src_b(issue_src_b), .issue_src_b_used(issue_src_b_used),
        .issue_dst(issue_dst), .issue_dst_used(issue_dst_used),
        .exec_busy(exec_busy), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
        .busy_mask(busy_mask), .inflight(inflight),
        .stall_cycles(stall_cycles), .wb_underflow(wb_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  a;
        logic        au;
        logic [3:0]  b;
        logic        bu;
        logic [3:0]  d;
        logic        du;
        logic        eb;
        logic        wv;
        logic [3:0]  wr;
        logic        fl;
        logic        rdy;
        logic [15:0] busy;
        logic [5:0]  infl;
        logic [31:0] stall;
        logic        uf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int v, a, au, b, bu, d, du, eb, wv, wr, fl,
                                input int rdy, busy, infl, stall, uf);
        vec_t r;
        r.v = 1'(v);   r.a = 4'(a);   r.au = 1'(au);
        r.b = 4'(b);   r.bu = 1'(bu); r.d = 4'(d);   r.du = 1'(du);
        r.eb = 1'(eb); r.wv = 1'(wv); r.wr = 4'(wr); r.fl = 1'(fl);
        r.rdy = 1'(rdy); r.busy = 16'(busy); r.infl = 6'(infl);
        r.stall = 32'(stall); r.uf = 1'(uf);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        issue_valid      = x.v;
        issue_src_a      = x.a;
        issue_src_a_used = x.au;
        issue_src_b      = x.b;
        issue_src_b_used = x.bu;
        issue_dst        = x.d;
        issue_dst_used   = x.du;
        exec_busy        = x.eb;
        wb_valid         = x.wv;
        wb_reg           = x.wr;
        flush            = x.fl;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    endtask

    // One cycle: inputs applied after negedge, ready checked before the edge,
    // registered outputs checked just after it.
    task automatic step(input vec_t x, input int idx);
        @(negedge clk);
        drive(x);
        #1;
        chk($sformatf("v%0d_ready", idx), 64'(issue_ready), 64'(x.rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_busy_mask", idx), 64'(busy_mask), 64'(x.busy));
        chk($sformatf("v%0d_inflight", idx), 64'(inflight), 64'(x.infl));
        chk($sformatf("v%0d_stall", idx), 64'(stall_cycles), 64'(x.stall));
        chk($sformatf("v%0d_underflow", idx), 64'(wb_underflow), 64'(x.uf));
    endtask

    initial begin
        //               v a au b bu d du eb wv wr fl  rdy busy  infl stall uf
        tbl.push_back(mk(1,0,0, 0,0, 5,1, 0, 0,0, 0,   1, 'h20, 1, 0, 0));
        tbl.push_back(mk(1,5,1, 0,0, 0,0, 0, 0,0, 0,   0, 'h20, 1, 1, 0));
        tbl.push_back(mk(1,5,1, 0,0, 0,0, 0, 0,0, 0,   0, 'h20, 1, 2, 0));
        tbl.push_back(mk(0,5,1, 0,0, 0,0, 0, 0,0, 0,   0, 'h20, 1, 2, 0));
        tbl.push_back(mk(1,5,1, 0,0, 0,0, 0, 1,5, 0,   0, 'h00, 0, 3, 0));
        tbl.push_back(mk(1,5,1, 0,0, 0,0, 0, 0,0, 0,   1, 'h00, 0, 3, 0));
        tbl.push_back(mk(1,0,0, 0,0, 2,1, 0, 0,0, 0,   1, 'h04, 1, 3, 0));
        tbl.push_back(mk(1,0,0, 0,0, 2,1, 0, 0,0, 0,   1, 'h04, 2, 3, 0));
        tbl.push_back(mk(1,0,0, 0,0, 2,1, 0, 0,0, 0,   1, 'h04, 3, 3, 0));
        tbl.push_back(mk(1,0,0, 0,0, 2,1, 0, 0,0, 0,   0, 'h04, 3, 4, 0));
        tbl.push_back(mk(1,0,0, 0,0, 2,1, 0, 1,2, 0,   0, 'h04, 2, 5, 0));
        tbl.push_back(mk(1,0,0, 0,0, 2,1, 0, 0,0, 0,   1, 'h04, 3, 5, 0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0, 1,2, 0,   1, 'h04, 2, 5, 0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0, 1,2, 0,   1, 'h04, 1, 5, 0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0, 1,2, 0,   1, 'h00, 0, 5, 0));
        tbl.push_back(mk(1,0,0, 0,0, 7,1, 0, 0,0, 0,   1, 'h80, 1, 5, 0));
        tbl.push_back(mk(1,0,0, 0,0, 7,1, 0, 1,7, 0,   1, 'h80, 1, 5, 0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0, 1,7, 0,   1, 'h00, 0, 5, 0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0, 1,9, 0,   1, 'h00, 0, 5, 1));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0, 0,0, 1,   1, 'h00, 0, 5, 1));
        tbl.push_back(mk(1,0,0, 0,0, 1,1, 0, 0,0, 0,   1, 'h02, 1, 5, 1));
        tbl.push_back(mk(1,0,0, 0,0, 1,1, 0, 0,0, 0,   1, 'h02, 2, 5, 1));
        tbl.push_back(mk(1,0,0, 0,0, 4,1, 0, 0,0, 0,   1, 'h12, 3, 5, 1));
        tbl.push_back(mk(1,0,0, 0,0, 6,1, 0, 0,0, 1,   1, 'h00, 0, 5, 1));
        tbl.push_back(mk(1,0,0, 0,0, 3,1, 0, 0,0, 0,   1, 'h08, 1, 5, 1));
        tbl.push_back(mk(1,3,1, 0,0, 3,1, 0, 0,0, 0,   0, 'h08, 1, 6, 1));
        tbl.push_back(mk(1,0,0, 3,1, 0,0, 0, 0,0, 0,   0, 'h08, 1, 7, 1));
        tbl.push_back(mk(1,3,0, 4,1, 3,1, 0, 0,0, 0,   1, 'h08, 2, 7, 1));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0, 1,3, 0,   1, 'h08, 1, 7, 1));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0, 1,3, 0,   1, 'h00, 0, 7, 1));

        // Reset state
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_mask", 64'(busy_mask), 64'h0);
        chk("rst_inflight", 64'(inflight), 64'h0);
        chk("rst_stall", 64'(stall_cycles), 64'h0);
        chk("rst_underflow", 64'(wb_underflow), 64'h0);
        chk("rst_ready", 64'(issue_ready), 64'h1);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i + 1);
        end

        // Asynchronous reset mid-operation, away from any clock edge
        step(mk(1,0,0,0,0,8,1,0,0,0,0, 1,'h100,1,7,1), 100);
        @(negedge clk);
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_busy_mask", 64'(busy_mask), 64'h0);
        chk("async_inflight", 64'(inflight), 64'h0);
        chk("async_stall", 64'(stall_cycles), 64'h0);
        chk("async_underflow", 64'(wb_underflow), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Flush suppresses the underflow of a same-cycle writeback; the
        // following stray writeback after reset raises it.
        step(mk(0,0,0,0,0,0,0,0,1,0,1, 1,0,0,0,0), 101);
        step(mk(0,0,0,0,0,0,0,0,1,0,0, 1,0,0,0,1), 102);

        // Execute busy with clean registers for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(mk(1,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0));
            #1;
            chk($sformatf("eb_ready_%0d", i), 64'(issue_ready), 64'h0);
        end
        @(posedge clk);
        #1;
        chk("eb_stall_10", 64'(stall_cycles), 64'd10);
        chk("eb_inflight", 64'(inflight), 64'h0);

        // Saturation: preload all-ones, keep stalling, counter must not wrap
        @(negedge clk);
        force dut.stall_cycles = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        release dut.stall_cycles;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_saturated", 64'(stall_cycles), 64'hFFFF_FFFF);
        @(negedge clk);
        drive(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        #1;
        chk("eb_release_ready", 64'(issue_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("stall_hold_no_stall", 64'(stall_cycles), 64'hFFFF_FFFF);
        @(negedge clk);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
